// File: rtl/reset_sequencer.sv
// reset_sequencer
// Sits between a simulation harness and the design top. It stretches the raw
// harness reset into a clean top_reset, then runs a bounded cycle counter.
// When the run ends (design halt, harness abort or cycle budget exhausted) it
// raises done with an exit code and holds it until the harness acknowledges.
//
// Phases:
//   HOLD - top_reset held high for HOLD_CYCLES cycles after reset falls
//   RUN  - design running, cycle_count counts completed RUN cycles
//   DONE - done=1 with a frozen exit_code/cycle_count, waiting for done_ack
//   IDLE - terminal until the next reset; results stay visible
module reset_sequencer #(
    parameter int unsigned HOLD_CYCLES = 4,     // must be >= 1
    parameter int unsigned MAX_CYCLES  = 10000, // must be < 2**COUNT_W
    parameter int unsigned COUNT_W     = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               halt_req,
    input  logic               abort_req,
    input  logic               done_ack,
    output logic               top_reset,
    output logic               running,
    output logic [COUNT_W-1:0] cycle_count,
    output logic               done,
    output logic [1:0]         exit_code
);

    // The hold counter only needs to reach HOLD_CYCLES-1; keep it at least
    // one bit wide so HOLD_CYCLES=1 still elaborates.
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);
    localparam logic [COUNT_W-1:0] COUNT_LAST = COUNT_W'(MAX_CYCLES - 1);
    localparam logic [COUNT_W-1:0] COUNT_ONE  = COUNT_W'(1);

    localparam logic [1:0] EXIT_NONE    = 2'b00;
    localparam logic [1:0] EXIT_HALT    = 2'b01;
    localparam logic [1:0] EXIT_TIMEOUT = 2'b10;
    localparam logic [1:0] EXIT_ABORT   = 2'b11;

    typedef enum logic [1:0] {
        S_HOLD = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10,
        S_IDLE = 2'b11
    } state_t;

    state_t             r_state;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic               r_top_reset;
    logic               r_running;
    logic [COUNT_W-1:0] r_cycle_count;
    logic               r_done;
    logic [1:0]         r_exit_code;

    logic               w_run_exit;
    logic [1:0]         w_exit_sel;

    // Decide whether RUN ends this cycle and why: abort beats halt beats timeout.
    always_comb begin
        w_run_exit = 1'b1;
        w_exit_sel = EXIT_NONE;
        if (abort_req) begin
            w_exit_sel = EXIT_ABORT;
        end else if (halt_req) begin
            w_exit_sel = EXIT_HALT;
        end else if (r_cycle_count == COUNT_LAST) begin
            w_exit_sel = EXIT_TIMEOUT;
        end else begin
            w_run_exit = 1'b0;
        end
    end

    // Sequencer FSM; every output comes straight from a register here.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_HOLD;
            r_hold_cnt    <= '0;
            r_top_reset   <= 1'b1;
            r_running     <= 1'b0;
            r_cycle_count <= '0;
            r_done        <= 1'b0;
            r_exit_code   <= EXIT_NONE;
        end else begin
            case (r_state)
                S_HOLD: begin
                    // Last hold cycle: release the design and start counting
                    // from zero on the following cycle.
                    if (r_hold_cnt == HOLD_LAST) begin
                        r_state     <= S_RUN;
                        r_top_reset <= 1'b0;
                        r_running   <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HOLD_ONE;
                    end
                end
                S_RUN: begin
                    // The exiting cycle is not counted, so cycle_count shows
                    // the value seen when the request or timeout was taken.
                    if (w_run_exit) begin
                        r_state     <= S_DONE;
                        r_running   <= 1'b0;
                        r_done      <= 1'b1;
                        r_exit_code <= w_exit_sel;
                    end else begin
                        r_cycle_count <= r_cycle_count + COUNT_ONE;
                    end
                end
                S_DONE: begin
                    // Results stay frozen; only the acknowledge is observed.
                    if (done_ack) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                S_IDLE: begin
                    // Terminal: hold everything until the next reset.
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_HOLD;
                end
            endcase
        end
    end

    assign top_reset   = r_top_reset;
    assign running     = r_running;
    assign cycle_count = r_cycle_count;
    assign done        = r_done;
    assign exit_code   = r_exit_code;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed testbench for reset_sequencer with HOLD_CYCLES=4, MAX_CYCLES=20.
// Inputs change 1 time unit after a rising edge and outputs are sampled at
// the same point, i.e. well away from the active edge.
module tb_reset_sequencer;

    localparam int unsigned HOLD_CYCLES = 4;
    localparam int unsigned MAX_CYCLES  = 20;
    localparam int unsigned COUNT_W     = 32;

    logic               clock;
    logic               reset;
    logic               halt_req;
    logic               abort_req;
    logic               done_ack;
    logic               top_reset;
    logic               running;
    logic [COUNT_W-1:0] cycle_count;
    logic               done;
    logic [1:0]         exit_code;

    int tests_run;
    int tests_failed;

    reset_sequencer #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .MAX_CYCLES  (MAX_CYCLES),
        .COUNT_W     (COUNT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .halt_req    (halt_req),
        .abort_req   (abort_req),
        .done_ack    (done_ack),
        .top_reset   (top_reset),
        .running     (running),
        .cycle_count (cycle_count),
        .done        (done),
        .exit_code   (exit_code)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Pulse reset for one edge, then let the 4-cycle hold elapse.
    // Leaves the DUT in its first RUN cycle with cycle_count=0.
    task automatic bring_up();
        halt_req  = 1'b0;
        abort_req = 1'b0;
        done_ack  = 1'b0;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        repeat (HOLD_CYCLES) tick();
    endtask

    // Reset state, then top_reset high for exactly 4 cycles after reset falls.
    task automatic test_reset();
        logic [4:0] st;
        reset = 1'b1;
        repeat (3) tick();
        st = {top_reset, running, done, exit_code};
        tests_run++;
        if (st !== 5'b1_0_0_00) begin
            tests_failed++;
            $display("FAIL reset_state: {top_reset,running,done,exit}=%b expected 10000", st);
        end
        tests_run++;
        if (cycle_count !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_count: cycle_count=%0d expected 0", cycle_count);
        end
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            tests_run++;
            if ({top_reset, running} !== 2'b10) begin
                tests_failed++;
                $display("FAIL hold_cycle_%0d: {top_reset,running}=%b expected 10", i, {top_reset, running});
            end
        end
        tick();
        tests_run++;
        if ({top_reset, running, cycle_count} !== {2'b01, 32'd0}) begin
            tests_failed++;
            $display("FAIL run_entry: top_reset=%b running=%b count=%0d expected 0 1 0",
                     top_reset, running, cycle_count);
        end
        tick();
        tests_run++;
        if (cycle_count !== 32'd1) begin
            tests_failed++;
            $display("FAIL run_count1: cycle_count=%0d expected 1", cycle_count);
        end
        $display("[TB] reset/hold: top_reset released after 4 hold cycles");
    endtask

    // No requests: timeout 20 cycles after running rose, count frozen at 19.
    task automatic test_timeout();
        bring_up();
        repeat (MAX_CYCLES - 1) tick();
        tests_run++;
        if ({running, done, cycle_count} !== {2'b10, 32'd19}) begin
            tests_failed++;
            $display("FAIL timeout_pre: running=%b done=%b count=%0d expected 1 0 19",
                     running, done, cycle_count);
        end
        tick();
        tests_run++;
        if ({top_reset, running, done, exit_code, cycle_count} !== {5'b0_0_1_10, 32'd19}) begin
            tests_failed++;
            $display("FAIL timeout_done: tr=%b run=%b done=%b exit=%b count=%0d expected 0 0 1 10 19",
                     top_reset, running, done, exit_code, cycle_count);
        end
        repeat (3) tick();
        tests_run++;
        if ({done, exit_code, cycle_count} !== {3'b1_10, 32'd19}) begin
            tests_failed++;
            $display("FAIL timeout_frozen: done=%b exit=%b count=%0d expected 1 10 19",
                     done, exit_code, cycle_count);
        end
        $display("[TB] timeout: exit=%b count=%0d", exit_code, cycle_count);
    endtask

    // Halt at count 7, hold done for 5 cycles, then acknowledge into IDLE.
    task automatic test_halt();
        bring_up();
        repeat (7) tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        tests_run++;
        if ({top_reset, running, done, exit_code, cycle_count} !== {5'b0_0_1_01, 32'd7}) begin
            tests_failed++;
            $display("FAIL halt_done: tr=%b run=%b done=%b exit=%b count=%0d expected 0 0 1 01 7",
                     top_reset, running, done, exit_code, cycle_count);
        end
        repeat (5) tick();
        tests_run++;
        if ({done, exit_code, cycle_count} !== {3'b1_01, 32'd7}) begin
            tests_failed++;
            $display("FAIL halt_held: done=%b exit=%b count=%0d expected 1 01 7",
                     done, exit_code, cycle_count);
        end
        done_ack = 1'b1;
        tick();
        done_ack = 1'b0;
        tests_run++;
        if ({top_reset, running, done, exit_code, cycle_count} !== {5'b0_0_0_01, 32'd7}) begin
            tests_failed++;
            $display("FAIL halt_ack: tr=%b run=%b done=%b exit=%b count=%0d expected 0 0 0 01 7",
                     top_reset, running, done, exit_code, cycle_count);
        end
        $display("[TB] halt: exit=%b count=%0d acknowledged", exit_code, cycle_count);
    endtask

    // abort beats halt mid-run and on the timeout cycle; halt beats timeout.
    task automatic test_priority();
        bring_up();
        repeat (3) tick();
        abort_req = 1'b1;
        halt_req  = 1'b1;
        tick();
        abort_req = 1'b0;
        halt_req  = 1'b0;
        tests_run++;
        if ({done, exit_code, cycle_count} !== {3'b1_11, 32'd3}) begin
            tests_failed++;
            $display("FAIL prio_mid: done=%b exit=%b count=%0d expected 1 11 3",
                     done, exit_code, cycle_count);
        end
        bring_up();
        repeat (MAX_CYCLES - 1) tick();
        abort_req = 1'b1;
        halt_req  = 1'b1;
        tick();
        abort_req = 1'b0;
        halt_req  = 1'b0;
        tests_run++;
        if ({done, exit_code, cycle_count} !== {3'b1_11, 32'd19}) begin
            tests_failed++;
            $display("FAIL prio_last: done=%b exit=%b count=%0d expected 1 11 19",
                     done, exit_code, cycle_count);
        end
        bring_up();
        repeat (MAX_CYCLES - 1) tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        tests_run++;
        if ({done, exit_code, cycle_count} !== {3'b1_01, 32'd19}) begin
            tests_failed++;
            $display("FAIL prio_halt_vs_timeout: done=%b exit=%b count=%0d expected 1 01 19",
                     done, exit_code, cycle_count);
        end
        $display("[TB] priority: abort over halt over timeout");
    endtask

    // Reset in RUN at count 12, and reset while done is pending.
    task automatic test_reset_mid();
        bring_up();
        repeat (12) tick();
        reset = 1'b1;
        tick();
        tests_run++;
        if ({top_reset, running, done, exit_code, cycle_count} !== {5'b1_0_0_00, 32'd0}) begin
            tests_failed++;
            $display("FAIL rst_run: tr=%b run=%b done=%b exit=%b count=%0d expected 1 0 0 00 0",
                     top_reset, running, done, exit_code, cycle_count);
        end
        reset = 1'b0;
        repeat (HOLD_CYCLES - 1) tick();
        tests_run++;
        if ({top_reset, running} !== 2'b10) begin
            tests_failed++;
            $display("FAIL rst_run_hold: {top_reset,running}=%b expected 10", {top_reset, running});
        end
        tick();
        tests_run++;
        if ({top_reset, running, cycle_count} !== {2'b01, 32'd0}) begin
            tests_failed++;
            $display("FAIL rst_run_rerun: tr=%b run=%b count=%0d expected 0 1 0",
                     top_reset, running, cycle_count);
        end
        repeat (2) tick();
        abort_req = 1'b1;
        tick();
        abort_req = 1'b0;
        reset = 1'b1;
        tick();
        tests_run++;
        if ({top_reset, running, done, exit_code, cycle_count} !== {5'b1_0_0_00, 32'd0}) begin
            tests_failed++;
            $display("FAIL rst_done: tr=%b run=%b done=%b exit=%b count=%0d expected 1 0 0 00 0",
                     top_reset, running, done, exit_code, cycle_count);
        end
        reset = 1'b0;
        repeat (HOLD_CYCLES - 1) tick();
        tests_run++;
        if ({top_reset, running, done} !== 3'b100) begin
            tests_failed++;
            $display("FAIL rst_done_hold: {top_reset,running,done}=%b expected 100",
                     {top_reset, running, done});
        end
        tick();
        tests_run++;
        if ({top_reset, running, cycle_count} !== {2'b01, 32'd0}) begin
            tests_failed++;
            $display("FAIL rst_done_rerun: tr=%b run=%b count=%0d expected 0 1 0",
                     top_reset, running, cycle_count);
        end
        $display("[TB] reset mid-operation: hold sequence repeated");
    endtask

    // Requests and acks during HOLD and IDLE must not change anything.
    task automatic test_spurious();
        halt_req  = 1'b0;
        abort_req = 1'b0;
        done_ack  = 1'b0;
        reset     = 1'b1;
        tick();
        reset     = 1'b0;
        halt_req  = 1'b1;
        abort_req = 1'b1;
        done_ack  = 1'b1;
        repeat (HOLD_CYCLES - 1) tick();
        tests_run++;
        if ({top_reset, running, done, exit_code} !== 5'b1_0_0_00) begin
            tests_failed++;
            $display("FAIL spur_hold: {tr,run,done,exit}=%b expected 10000",
                     {top_reset, running, done, exit_code});
        end
        halt_req  = 1'b0;
        abort_req = 1'b0;
        done_ack  = 1'b0;
        tick();
        tests_run++;
        if ({top_reset, running, cycle_count} !== {2'b01, 32'd0}) begin
            tests_failed++;
            $display("FAIL spur_hold_exit: tr=%b run=%b count=%0d expected 0 1 0",
                     top_reset, running, cycle_count);
        end
        done_ack = 1'b1;
        repeat (2) tick();
        done_ack = 1'b0;
        tests_run++;
        if ({running, done, cycle_count} !== {2'b10, 32'd2}) begin
            tests_failed++;
            $display("FAIL spur_ack_run: run=%b done=%b count=%0d expected 1 0 2",
                     running, done, cycle_count);
        end
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        done_ack = 1'b1;
        tick();
        done_ack  = 1'b1;
        halt_req  = 1'b1;
        abort_req = 1'b1;
        repeat (4) tick();
        tests_run++;
        if ({top_reset, running, done, exit_code, cycle_count} !== {5'b0_0_0_01, 32'd2}) begin
            tests_failed++;
            $display("FAIL spur_idle: tr=%b run=%b done=%b exit=%b count=%0d expected 0 0 0 01 2",
                     top_reset, running, done, exit_code, cycle_count);
        end
        halt_req  = 1'b0;
        abort_req = 1'b0;
        done_ack  = 1'b0;
        $display("[TB] spurious: inputs ignored in HOLD and IDLE");
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        halt_req     = 1'b0;
        abort_req    = 1'b0;
        done_ack     = 1'b0;
        test_reset();
        test_timeout();
        test_halt();
        test_priority();
        test_reset_mid();
        test_spurious();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
